// File: rtl/datapath_pkg.sv
// Shared types for the game datapath: command word layout and the sequence ROM rule.
// The ROM is a pure function of (bank, index), so no storage is needed.
`timescale 1ns/1ps
package datapath_pkg;
    localparam int BANK_W = 2;
    localparam int IDX_W  = 4;
    localparam int VAL_W  = 4;

    // Command word from the game controller, MSB first.
    typedef struct packed {
        logic r2;
        logic r1;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } cmd_t;

    // ROM(b,i) = (5*i + 3*b + 1) mod 16
    function automatic logic [VAL_W-1:0] rom_value(input logic [BANK_W-1:0] bank,
                                                   input logic [IDX_W-1:0]  idx);
        logic [7:0] sum;
        sum = 8'(idx) * 8'd5 + 8'(bank) * 8'd3 + 8'd1;
        return sum[VAL_W-1:0];
    endfunction
endpackage

// File: rtl/datapath_if.sv
// Controller <-> datapath bundle: command word, user inputs and returned status/display.
// Master is the controller/board side, slave is the datapath.
`timescale 1ns/1ps
interface datapath_if;
    import datapath_pkg::*;

    cmd_t             cmd;
    logic             enter;
    logic [3:0]       sw;
    logic             end_fpga;
    logic             end_user;
    logic             end_time;
    logic             win;
    logic             match;
    logic [IDX_W-1:0] round;
    logic [VAL_W-1:0] disp_value;

    modport master (
        output cmd, enter, sw,
        input  end_fpga, end_user, end_time, win, match, round, disp_value
    );

    modport slave (
        input  cmd, enter, sw,
        output end_fpga, end_user, end_time, win, match, round, disp_value
    );
endinterface

// File: rtl/datapath_seq_rom.sv
// Sequence ROM: combinational read of bank/index to a 4-bit element, zero latency.
// No handshake; the output follows the address in the same cycle.
`timescale 1ns/1ps
module seq_rom
    import datapath_pkg::*;
(
    input  logic [BANK_W-1:0] bank,
    input  logic [IDX_W-1:0]  idx,
    output logic [VAL_W-1:0]  value
);
    assign value = rom_value(bank, idx);
endmodule

// File: rtl/datapath.sv
// Game datapath: executes controller commands, holds sequence/round/index/timer state.
// Status is registered (visible one cycle after the edge); win and disp_value are combinational; no backpressure.
`timescale 1ns/1ps
module datapath
    import datapath_pkg::*;
#(
    parameter int unsigned SHOW_TICKS    = 50000000,
    parameter int unsigned TIMEOUT_TICKS = 250000000,
    parameter int unsigned N_ROUNDS      = 16
) (
    input logic       clock_50,
    input logic       reset,
    datapath_if.slave dp
);
    localparam logic [31:0]      SHOW_LAST    = 32'(SHOW_TICKS - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_TICKS - 1);
    localparam logic [IDX_W-1:0] ROUND_LAST   = IDX_W'(N_ROUNDS - 1);

    logic [BANK_W-1:0] bank_q, bank_d;
    logic [IDX_W-1:0]  round_q, round_d;
    logic [IDX_W-1:0]  fpga_idx_q, fpga_idx_d;
    logic [IDX_W-1:0]  user_idx_q, user_idx_d;
    logic [31:0]       tick_q, tick_d;
    logic [31:0]       timer_q, timer_d;
    logic [VAL_W-1:0]  user_last_q, user_last_d;
    logic              end_fpga_q, end_fpga_d;
    logic              end_user_q, end_user_d;
    logic              end_time_q, end_time_d;
    logic              match_q, match_d;

    logic [VAL_W-1:0]  fpga_val;
    logic [VAL_W-1:0]  expect_val;

    seq_rom u_rom_disp (.bank(bank_q), .idx(fpga_idx_q), .value(fpga_val));
    seq_rom u_rom_cmp  (.bank(bank_q), .idx(user_idx_q), .value(expect_val));

    always_comb begin
        bank_d      = bank_q;
        round_d     = round_q;
        fpga_idx_d  = fpga_idx_q;
        user_idx_d  = user_idx_q;
        tick_d      = tick_q;
        timer_d     = timer_q;
        user_last_d = user_last_q;
        end_fpga_d  = end_fpga_q;
        end_user_d  = end_user_q;
        end_time_d  = end_time_q;
        match_d     = match_q;

        if (dp.cmd.r2 || dp.cmd.r1) begin
            fpga_idx_d  = '0;
            user_idx_d  = '0;
            tick_d      = '0;
            timer_d     = '0;
            user_last_d = '0;
            end_fpga_d  = 1'b0;
            end_user_d  = 1'b0;
            end_time_d  = 1'b0;
            match_d     = 1'b1;
            if (dp.cmd.r2) begin
                bank_d  = '0;
                round_d = '0;
            end
        end else begin
            if (dp.cmd.e1) begin
                bank_d = dp.sw[BANK_W-1:0];
            end

            if (dp.cmd.e2 && !end_fpga_q) begin
                if (tick_q == SHOW_LAST) begin
                    tick_d = '0;
                    if (fpga_idx_q == round_q) end_fpga_d = 1'b1;
                    else                       fpga_idx_d = fpga_idx_q + 1'b1;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end

            // An entry in the expiry cycle still counts; both flags may set together.
            if (dp.cmd.e3 && !end_user_q && !end_time_q) begin
                if (timer_q == TIMEOUT_LAST) end_time_d = 1'b1;
                else                         timer_d    = timer_q + 32'd1;
                if (dp.enter) begin
                    user_last_d = dp.sw;
                    if (dp.sw != expect_val) match_d = 1'b0;
                    if (user_idx_q == round_q) end_user_d = 1'b1;
                    else                       user_idx_d = user_idx_q + 1'b1;
                end
            end

            if (dp.cmd.e4 && (round_q < ROUND_LAST)) begin
                round_d = round_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            bank_q      <= '0;
            round_q     <= '0;
            fpga_idx_q  <= '0;
            user_idx_q  <= '0;
            tick_q      <= '0;
            timer_q     <= '0;
            user_last_q <= '0;
            end_fpga_q  <= 1'b0;
            end_user_q  <= 1'b0;
            end_time_q  <= 1'b0;
            match_q     <= 1'b1;
        end else begin
            bank_q      <= bank_d;
            round_q     <= round_d;
            fpga_idx_q  <= fpga_idx_d;
            user_idx_q  <= user_idx_d;
            tick_q      <= tick_d;
            timer_q     <= timer_d;
            user_last_q <= user_last_d;
            end_fpga_q  <= end_fpga_d;
            end_user_q  <= end_user_d;
            end_time_q  <= end_time_d;
            match_q     <= match_d;
        end
    end

    assign dp.end_fpga   = end_fpga_q;
    assign dp.end_user   = end_user_q;
    assign dp.end_time   = end_time_q;
    assign dp.match      = match_q;
    assign dp.round      = round_q;
    assign dp.win        = end_user_q & match_q & (round_q == ROUND_LAST);
    assign dp.disp_value = dp.cmd.sel ? user_last_q : fpga_val;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed game scenarios plus random command streams,
// all outputs compared every cycle against a counting model of the game rules.
`timescale 1ns/1ps
module tb_datapath;
    import datapath_pkg::*;

    localparam int SHOW = 4;
    localparam int TMO  = 20;
    localparam int NR   = 3;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R2   = 7'b1000000;
    localparam logic [6:0] C_R1   = 7'b0100000;
    localparam logic [6:0] C_E1   = 7'b0010000;
    localparam logic [6:0] C_E2   = 7'b0001000;
    localparam logic [6:0] C_E3   = 7'b0000100;
    localparam logic [6:0] C_E4   = 7'b0000010;
    localparam logic [6:0] C_SEL  = 7'b0000001;

    logic clock_50 = 1'b0;
    logic reset    = 1'b0;

    datapath_if dp();

    datapath #(.SHOW_TICKS(SHOW), .TIMEOUT_TICKS(TMO), .N_ROUNDS(NR)) u_dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .dp       (dp)
    );

    always #5 clock_50 = ~clock_50;

    int n_cmp = 0;
    int n_err = 0;

    // Game model: counts of enabled cycles and accepted entries.
    int m_bank      = 0;
    int m_round     = 0;
    int m_shown     = 0;
    int m_nent      = 0;
    int m_timer     = 0;
    int m_user_last = 0;
    bit m_end_fpga  = 0;
    bit m_end_user  = 0;
    bit m_end_time  = 0;
    bit m_match     = 1;

    function automatic int ref_rom(input int b, input int i);
        return (5 * i + 3 * b + 1) % 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear_round();
        m_shown = 0; m_nent = 0; m_timer = 0; m_user_last = 0;
        m_end_fpga = 0; m_end_user = 0; m_end_time = 0; m_match = 1;
    endtask

    task automatic m_step();
        cmd_t c;
        c = dp.cmd;
        if (c.r2) begin
            m_clear_round(); m_bank = 0; m_round = 0;
        end else if (c.r1) begin
            m_clear_round();
        end else begin
            if (c.e2 && !m_end_fpga) begin
                m_shown++;
                if (m_shown == (m_round + 1) * SHOW) m_end_fpga = 1;
            end
            if (c.e3 && !m_end_user && !m_end_time) begin
                m_timer++;
                if (dp.enter) begin
                    m_user_last = int'(dp.sw);
                    if (int'(dp.sw) != ref_rom(m_bank, m_nent)) m_match = 0;
                    m_nent++;
                    if (m_nent == m_round + 1) m_end_user = 1;
                end
                if (m_timer == TMO) m_end_time = 1;
            end
            if (c.e4 && m_round < NR - 1) m_round++;
            if (c.e1) m_bank = int'(dp.sw[1:0]);
        end
    endtask

    always @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            m_clear_round(); m_bank = 0; m_round = 0;
        end else begin
            m_step();
        end
    end

    always @(posedge clock_50) begin
        int fidx;
        int exp_disp;
        #2;
        fidx     = m_end_fpga ? (m_shown / SHOW) - 1 : m_shown / SHOW;
        exp_disp = dp.cmd.sel ? m_user_last : ref_rom(m_bank, fidx);
        chk("end_fpga", 32'(dp.end_fpga), 32'(m_end_fpga));
        chk("end_user", 32'(dp.end_user), 32'(m_end_user));
        chk("end_time", 32'(dp.end_time), 32'(m_end_time));
        chk("match",    32'(dp.match),    32'(m_match));
        chk("round",    32'(dp.round),    32'(m_round));
        chk("win",      32'(dp.win),      32'(m_end_user && m_match && m_round == NR - 1));
        chk("disp",     32'(dp.disp_value), 32'(exp_disp));
    end

    task automatic step(input logic [6:0] c, input logic en, input logic [3:0] s);
        @(negedge clock_50);
        dp.cmd   = cmd_t'(c);
        dp.enter = en;
        dp.sw    = s;
        @(posedge clock_50);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    int game_vals [3] = '{1, 6, 11};

    initial begin
        int k;
        dp.cmd   = cmd_t'(C_NONE);
        dp.enter = 1'b0;
        dp.sw    = 4'd0;
        repeat (3) @(negedge clock_50);
        chk("rst_round", 32'(dp.round), 0);
        chk("rst_match", 32'(dp.match), 1);
        chk("rst_end",   32'({dp.end_fpga, dp.end_user, dp.end_time}), 0);
        chk("rst_win",   32'(dp.win), 0);
        chk("rst_disp",  32'(dp.disp_value), 1);
        reset = 1'b1;

        step(C_R2, 1'b0, 4'd0);
        chk("r2_round", 32'(dp.round), 0);
        chk("r2_match", 32'(dp.match), 1);
        chk("r2_disp",  32'(dp.disp_value), 1);

        // Bank 1, round 0: one element (value 4) takes exactly SHOW cycles.
        step(C_E1, 1'b0, 4'd1);
        step(C_R1, 1'b0, 4'd0);
        k = 0;
        while (!dp.end_fpga && k < 16) begin
            step(C_E2, 1'b0, 4'd0);
            k++;
            chk("fpga0_disp", 32'(dp.disp_value), 4);
        end
        chk("fpga0_cycles", 32'(k), 4);

        // Round 1: two elements 4 then 9, eight cycles in total.
        step(C_E4, 1'b0, 4'd0);
        chk("round1", 32'(dp.round), 1);
        step(C_R1, 1'b0, 4'd0);
        for (int i = 1; i <= 8; i++) begin
            step(C_E2, 1'b0, 4'd0);
            chk("fpga1_disp", 32'(dp.disp_value), (i < 4) ? 4 : 9);
            if (i == 7) chk("fpga1_not_yet", 32'(dp.end_fpga), 0);
        end
        chk("fpga1_end", 32'(dp.end_fpga), 1);

        step(C_R1, 1'b0, 4'd0);
        step(C_E3, 1'b1, 4'd4);
        chk("u_first_not_end", 32'(dp.end_user), 0);
        step(C_E3, 1'b0, 4'd0);
        step(C_E3, 1'b1, 4'd9);
        chk("u_ok_end",   32'(dp.end_user), 1);
        chk("u_ok_match", 32'(dp.match), 1);
        step(C_E3 | C_SEL, 1'b0, 4'd0);
        chk("u_ok_disp", 32'(dp.disp_value), 9);
        chk("u_ok_win",  32'(dp.win), 0);

        step(C_R1, 1'b0, 4'd0);
        step(C_E3, 1'b1, 4'd4);
        step(C_E3, 1'b1, 4'd3);
        chk("u_bad_match", 32'(dp.match), 0);
        chk("u_bad_end",   32'(dp.end_user), 1);
        chk("u_bad_win",   32'(dp.win), 0);

        // Timeout after TMO enabled cycles; later entries are ignored.
        step(C_R1, 1'b0, 4'd0);
        for (int i = 1; i <= TMO; i++) begin
            step(C_E3, 1'b0, 4'd0);
            if (i == TMO - 1) chk("tmo_early", 32'(dp.end_time), 0);
        end
        chk("tmo_set", 32'(dp.end_time), 1);
        step(C_E3 | C_SEL, 1'b1, 4'd7);
        chk("tmo_last", 32'(dp.disp_value), 0);
        chk("tmo_no_end_user", 32'(dp.end_user), 0);

        // Full game on bank 0: elements 1, 6, 11.
        step(C_R2, 1'b0, 4'd0);
        for (int r = 0; r < NR; r++) begin
            step(C_R1, 1'b0, 4'd0);
            for (int i = 0; i <= r; i++) step(C_E3, 1'b1, 4'(game_vals[i]));
            chk("game_end_user", 32'(dp.end_user), 1);
            chk("game_match",    32'(dp.match), 1);
            chk("game_win",      32'(dp.win), (r == NR - 1) ? 1 : 0);
            if (r < NR - 1) step(C_E4, 1'b0, 4'd0);
        end
        step(C_E4, 1'b0, 4'd0);
        chk("sat_round", 32'(dp.round), 2);
        chk("sat_win",   32'(dp.win), 1);
        step(C_R2, 1'b0, 4'd0);
        chk("r2_clr_win",   32'(dp.win), 0);
        chk("r2_clr_round", 32'(dp.round), 0);

        // Random command streams with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] c;
            logic       en;
            logic [3:0] s;
            c    = C_NONE;
            c[6] = ($urandom_range(63) == 0);
            c[5] = ($urandom_range(15) == 0);
            c[4] = ($urandom_range(7) == 0);
            c[3] = 1'($urandom_range(1));
            c[2] = ($urandom_range(3) != 0);
            c[1] = ($urandom_range(15) == 0);
            c[0] = 1'($urandom_range(1));
            en   = ($urandom_range(3) == 0);
            s    = ($urandom_range(1) == 1) ? 4'(ref_rom(m_bank, m_nent)) : 4'($urandom_range(15));
            if ($urandom_range(255) == 0) begin
                @(negedge clock_50);
                #2;
                reset = 1'b0;
                #1;
                chk("arst_round", 32'(dp.round), 0);
                chk("arst_match", 32'(dp.match), 1);
                @(negedge clock_50);
                reset = 1'b1;
            end
            step(c, en, s);
        end

        step(C_NONE, 1'b0, 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
